// File: rtl/trig_pkg.sv
// trig_seq shared package: state encoding, widths, helpers.
// Imported by the sequencer top and its channel selector.
package trig_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_CNT_LEN  = 16;
  localparam int DEF_HOLD_LEN = 24;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/trig_chan_sel.sv
// Channel selector: lowest set bit and next set bit above idx.
// Purely combinational; shared by start and wrap decisions.
module trig_chan_sel
  import trig_pkg::*;
#(
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int IDX_LEN  = idx_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] mask_i,
  input  logic [IDX_LEN-1:0]  idx_i,
  output logic [IDX_LEN-1:0]  nxt_o,
  output logic [IDX_LEN-1:0]  low_o,
  output logic                has_next_o,
  output logic                any_o
);

  // Descending scan so the lowest qualifying bit is written last.
  always_comb begin
    nxt_o      = '0;
    low_o      = '0;
    has_next_o = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        low_o = IDX_LEN'(i);
        if (i > int'(idx_i)) begin
          nxt_o      = IDX_LEN'(i);
          has_next_o = 1'b1;
        end
      end
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/trig_seq.sv
// Multi-channel HC-SR04 trigger sequencer with per-pulse hold-off.
// Fires each enabled channel in ascending order, optionally looping.
module trig_seq
  import trig_pkg::*;
#(
  parameter  int CHANNELS = DEF_CHANNELS,
  parameter  int CNT_LEN  = DEF_CNT_LEN,
  parameter  int HOLD_LEN = DEF_HOLD_LEN,
  localparam int IDX_LEN  = idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic [CHANNELS-1:0] chan_mask,
  input  logic [CNT_LEN-1:0]  pulse_width,
  input  logic [HOLD_LEN-1:0] holdoff,
  output logic                ready,
  output logic                busy,
  output logic [CHANNELS-1:0] sig,
  output logic [IDX_LEN-1:0]  chan_idx,
  output logic                fired
);

  logic [1:0]          state_q, state_d;
  logic                sp_q, sp_d;
  logic                mode_q, mode_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [CHANNELS-1:0] sig_q, sig_d;
  logic [CNT_LEN-1:0]  pw_q, pw_d;
  logic [CNT_LEN-1:0]  pcnt_q, pcnt_d;
  logic [HOLD_LEN-1:0] ho_q, ho_d;
  logic [HOLD_LEN-1:0] hcnt_q, hcnt_d;
  logic [IDX_LEN-1:0]  idx_q, idx_d;
  logic                fired_q, fired_d;

  logic                rise;
  logic [IDX_LEN-1:0]  nxt_idx, in_low;
  logic                has_next, in_any;
  logic [IDX_LEN-1:0]  cur_low_unused, in_nxt_unused;
  logic                cur_any_unused, in_has_unused;
  logic [CNT_LEN-1:0]  wp_m1;
  logic [HOLD_LEN-1:0] wh_m1;

  trig_chan_sel #(.CHANNELS(CHANNELS)) u_cur (
    .mask_i     (mask_q),
    .idx_i      (idx_q),
    .nxt_o      (nxt_idx),
    .low_o      (cur_low_unused),
    .has_next_o (has_next),
    .any_o      (cur_any_unused)
  );

  trig_chan_sel #(.CHANNELS(CHANNELS)) u_in (
    .mask_i     (chan_mask),
    .idx_i      (idx_q),
    .nxt_o      (in_nxt_unused),
    .low_o      (in_low),
    .has_next_o (in_has_unused),
    .any_o      (in_any)
  );

  assign rise  = start & ~sp_q;
  assign wp_m1 = (pw_q == '0) ? '0 : pw_q - CNT_LEN'(1);
  assign wh_m1 = (ho_q == '0) ? '0 : ho_q - HOLD_LEN'(1);

  always_comb begin
    state_d = state_q;
    sp_d    = start;
    mode_d  = mode_q;
    mask_d  = mask_q;
    sig_d   = sig_q;
    pw_d    = pw_q;
    pcnt_d  = pcnt_q;
    ho_d    = ho_q;
    hcnt_d  = hcnt_q;
    idx_d   = idx_q;
    fired_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      sig_d   = '0;
    end else begin
      unique case (1'b1)
        (state_q == IDLE): begin
          if (rise && in_any) begin
            mode_d  = mode;
            mask_d  = chan_mask;
            pw_d    = pulse_width;
            ho_d    = holdoff;
            idx_d   = in_low;
            pcnt_d  = '0;
            hcnt_d  = '0;
            sig_d   = CHANNELS'(1) << in_low;
            state_d = PULSE;
          end
        end
        (state_q == PULSE): begin
          if (pcnt_q == wp_m1) begin
            pcnt_d  = '0;
            hcnt_d  = '0;
            sig_d   = '0;
            fired_d = 1'b1;
            state_d = HOLD;
          end else begin
            pcnt_d = pcnt_q + CNT_LEN'(1);
          end
        end
        (state_q == HOLD): begin
          if (hcnt_q == wh_m1) begin
            hcnt_d = '0;
            pcnt_d = '0;
            if (has_next) begin
              idx_d   = nxt_idx;
              sig_d   = CHANNELS'(1) << nxt_idx;
              state_d = PULSE;
            end else if (mode_q) begin
              // Wrap: pick up fresh config from the inputs.
              mask_d = chan_mask;
              pw_d   = pulse_width;
              ho_d   = holdoff;
              if (in_any) begin
                idx_d   = in_low;
                sig_d   = CHANNELS'(1) << in_low;
                state_d = PULSE;
              end else begin
                state_d = IDLE;
              end
            end else begin
              state_d = IDLE;
            end
          end else begin
            hcnt_d = hcnt_q + HOLD_LEN'(1);
          end
        end
        default: begin
          state_d = IDLE;
          sig_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sp_q    <= 1'b0;
      mode_q  <= 1'b0;
      mask_q  <= '0;
      sig_q   <= '0;
      pw_q    <= '0;
      pcnt_q  <= '0;
      ho_q    <= '0;
      hcnt_q  <= '0;
      idx_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      sig_q   <= sig_d;
      pw_q    <= pw_d;
      pcnt_q  <= pcnt_d;
      ho_q    <= ho_d;
      hcnt_q  <= hcnt_d;
      idx_q   <= idx_d;
      fired_q <= fired_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign busy     = ~ready;
  assign sig      = sig_q;
  assign chan_idx = idx_q;
  assign fired    = fired_q;

endmodule

// File: doc/trig_seq.md
# trig_seq

Multi-channel HC-SR04 trigger sequencer, the parametrised successor to the single-channel trigger generator. On a start edge it fires a programmable-width trigger pulse on each enabled channel in ascending index order. Every pulse is followed by a programmable hold-off so echoes from one sensor die out before the next one fires. In continuous mode it loops over the mask until aborted. It sits between the control register block and the per-sensor echo timers, which use `fired`/`chan_idx` to arm their capture.

## Interface
- `CHANNELS`, default 4: number of trigger outputs, at least 1.
- `CNT_LEN`, default 16: width of the pulse-width counter.
- `HOLD_LEN`, default 24: width of the hold-off counter.
- `IDX_LEN`, derived: clog2(CHANNELS), minimum 1.

- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `start` in 1: level input; its rising edge requests a sequence.
- `abort` in 1: level input; when high, terminates any sequence.
- `mode` in 1: 0 = single pass over mask, 1 = continuous.
- `chan_mask` in CHANNELS: enabled channels.
- `pulse_width` in CNT_LEN: trigger high time in cycles.
- `holdoff` in HOLD_LEN: low time after each pulse in cycles.
- `ready` out 1: high in IDLE.
- `busy` out 1: equals !ready.
- `sig` out CHANNELS: trigger outputs, at most one bit high.
- `chan_idx` out IDX_LEN: channel currently pulsing or holding.
- `fired` out 1: one-cycle strobe on the first HOLD cycle of each channel.

## Operation
- States are IDLE, PULSE and HOLD.
- **Start edge.** `rise` = start & !start_prev. `start_prev` is a register that updates every cycle in every state.
- **IDLE -> PULSE** on `rise` with a nonzero `chan_mask`, when `abort` is low.
  - Latch `mode`, `chan_mask`, `pulse_width` and `holdoff` into shadow registers.
  - Set `chan_idx` to the lowest set bit and clear the counter.
  - A start with a zero mask is ignored and the block stays in IDLE.
- **PULSE.**
  - `sig[chan_idx]` is high and the counter increments.
  - Exit to HOLD after max(pulse_width, 1) cycles. Clear the counter and assert `fired` for that first HOLD cycle.
- **HOLD.**
  - All `sig` bits are low.
  - Exit after max(holdoff, 1) cycles to the next set bit above `chan_idx` in the latched mask, entering PULSE.
  - If no set bit remains: in mode 1, re-latch `chan_mask`/`pulse_width`/`holdoff` from the inputs and wrap to the lowest set bit. If the new mask is zero, go to IDLE.
  - If no set bit remains in mode 0, go to IDLE.
- **Abort.**
  - `abort` high in any state: go to IDLE at that edge, with `sig` all low and `fired` low from that edge on.
  - `abort` and `rise` in the same cycle: abort wins.
- **Config changes.** A `rise` while busy is ignored. Input changes while busy have no effect until the next wrap (mode 1) or the next start.
- **Reset values.**
  - State is IDLE, so `ready`=1 and `busy`=0.
  - `sig`=0, `chan_idx`=0 and `fired`=0.
  - Counters, shadow registers and `start_prev` are all 0.

## Timing
- All outputs are registered.
- **Start latency.** If `rise` is sampled at edge k, `sig` goes high and `ready` goes low immediately after edge k.
- **Pulse.** `sig` stays high for exactly max(pulse_width, 1) cycles.
- **Hold.** The low gap between consecutive pulses is exactly max(holdoff, 1) cycles.
- **Period.** Per channel it is Wp + Wh cycles, where Wp = max(pulse_width, 1) and Wh = max(holdoff, 1).
- **Single pass.** A mode-0 pass over N enabled channels takes N·(Wp + Wh) cycles from the first `sig` rise to `ready`=1.
- **Restart.** At least 2 cycles separate the return to IDLE and the next possible start: start must drop for one cycle before a new rise.
- **Reset.** Reset mid-sequence clears `sig` at that same edge. No partial pulse is stretched.

## Structure
- Package `trig_pkg` holds:
  - the state encoding constants IDLE=0, PULSE=1, HOLD=2 (2-bit);
  - a clog2 helper function;
  - the default widths.
- Sub-module `trig_chan_sel` is purely combinational. Inputs are the mask and the current index. Outputs are the next set index above current, the lowest set index, a `has_next` flag and an `any` flag. It is used for both the start and wrap decisions.

## Test plan
- Reset, then CHANNELS=4, mask=4'b1010, W=3, H=5, mode 0, start rise at edge 10:
  - `sig[1]` high for edges 10–12 and low for 13–17;
  - `sig[3]` high for 18–20 and low for 21–25;
  - `fired` at 13 and 21;
  - `ready`=1 at 26.
- pulse_width=0 and holdoff=0, mask=4'b0001, mode 1: `sig[0]` toggles 1 cycle high, 1 cycle low indefinitely.
- Mode 1 with mask=4'b0011, mask changed to 4'b0100 mid-pass: the current pass finishes on ch1, the next pulse is on ch2, and `chan_idx`=2.
- Abort during PULSE on ch2 (W=10, abort at the 4th pulse cycle): `sig`=0 and `ready`=1 after that edge, and no `fired` strobe.
- Start held high across the end of a sequence: no retrigger until start falls and rises again. A start rise with mask=0 leaves `ready`=1.
- rst=0 asserted during HOLD: all outputs return to reset values at that edge, and a subsequent start behaves as from cold.
